// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encoding,
// opcode constants and the datapath select / ALU / immediate codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The master modport is the controller side.
// Optional port: illegal, present only when ILLEGAL_TRAP_EN is defined.
//
// Handshake: mem_ready is a completion strobe from memory. While the
// controller sits in FETCH, MEMREAD or MEMWRITE it holds the access
// (address select and, for stores, mem_write) stable; the access completes
// in the cycle mem_ready is 1 and the state advances on that clock edge.
// mem_ready is ignored in every other state.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       sign;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] imm_src;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7_5, zero, sign, mem_ready,
`ifdef ILLEGAL_TRAP_EN
    output illegal,
`endif
    output pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, state
  );

  modport slave (
    output op, funct3, funct7_5, zero, sign, mem_ready,
`ifdef ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, state
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// ALU operation select. Branches always subtract (flags drive the compare);
// ALU-type instructions decode funct3, with funct7_5 selecting sub only for
// R-type; every other state uses add (address and PC arithmetic).
module mc_alu_decoder
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_control_o
);

  // Combinational ALU operation decode
  always_comb begin
    alu_control_o = ALU_ADD;
    case (state_i)
      S_BRANCH: alu_control_o = ALU_SUB;
      S_EXECUTER, S_EXECUTEI: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op_i == OP_RTYPE && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          3'b100:  alu_control_o = ALU_XOR;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle RV32I control unit for a shared-ALU, single-memory
// datapath. Optional feature macro: ILLEGAL_TRAP_EN -- when defined, an
// unsupported opcode parks the FSM in ILLEGAL (illegal=1) until reset;
// otherwise the instruction retires as a one-cycle NOP.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c;
  logic       adr_src_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c;
  logic [2:0] imm_src_c;
  logic [2:0] alu_control_c;
  logic       branch_taken;

  // State register; reset returns to FETCH asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Branch condition from the subtract flags
  always_comb begin
    branch_taken = 1'b0;
    case (bus.funct3)
      3'b000:  branch_taken = bus.zero;
      3'b001:  branch_taken = !bus.zero;
      3'b100:  branch_taken = bus.sign;
      3'b101:  branch_taken = !bus.sign;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state and datapath controls per state
  always_comb begin
    state_d      = S_FETCH;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RD2;
    imm_src_c    = IMM_I;
    case (state_q)
      S_FETCH: begin
        adr_src_c    = 1'b0;
        ir_write_c   = bus.mem_ready;
        pc_write_c   = bus.mem_ready;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALU;
        state_d      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = (bus.op == OP_LOAD) ? IMM_I : IMM_S;
        state_d     = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_c    = 1'b1;
        result_src_c = RES_ALUOUT;
        state_d      = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_c = RES_DATA;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_c    = 1'b1;
        result_src_c = RES_ALUOUT;
        mem_write_c  = 1'b1;
        state_d      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_RD2;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_I;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut still holds the target computed in DECODE
        alu_src_a_c  = SRCA_RD1;
        alu_src_b_c  = SRCB_RD2;
        result_src_c = RES_ALUOUT;
        pc_write_c   = branch_taken;
        state_d      = S_FETCH;
      end
      S_JALR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_I;
        state_d     = S_JAL;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while ALUOut captures OldPC+4
        result_src_c = RES_ALUOUT;
        pc_write_c   = 1'b1;
        alu_src_a_c  = SRCA_OLDPC;
        alu_src_b_c  = SRCB_FOUR;
        state_d      = S_ALUWB;
      end
      S_LUI: begin
        imm_src_c    = IMM_U;
        result_src_c = RES_IMM;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .state_i       (state_q),
    .op_i          (bus.op),
    .funct3_i      (bus.funct3),
    .funct7_5_i    (bus.funct7_5),
    .alu_control_o (alu_control_c)
  );

  // Write enables are forced low while reset is held, since FETCH would
  // otherwise follow mem_ready
  assign bus.pc_write    = pc_write_c  & rst_n;
  assign bus.ir_write    = ir_write_c  & rst_n;
  assign bus.reg_write   = reg_write_c & rst_n;
  assign bus.mem_write   = mem_write_c & rst_n;
  assign bus.adr_src     = adr_src_c;
  assign bus.result_src  = result_src_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.alu_control = alu_control_c;
  assign bus.imm_src     = imm_src_c;
  assign bus.state       = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal     = (state_q == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. The reference model expands each
// instruction into its expected per-cycle trace (state, write enables and the
// selects that matter in that cycle) from the instruction class and the
// chosen memory stall counts; the driver replays the trace cycle by cycle.
module tb_multicycle_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One expected cycle: inputs to drive plus expected outputs and care mask.
  // Output vector: {pc_write, ir_write, reg_write, mem_write, adr_src,
  //                 result_src, alu_src_a, alu_src_b, alu_control, imm_src}
  typedef struct packed {
    logic [3:0]  st;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        mr;
    logic        zr;
    logic        sg;
    logic [16:0] ov;
    logic [16:0] mk;
  } cyc_t;
  localparam int W = $bits(cyc_t);

  logic [W-1:0] exp_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [6:0]   b_op;
  logic [2:0]   b_f3;
  logic         b_f7;

  localparam logic [6:0] LEGAL_OPS [8] = '{7'b0000011, 7'b0100011, 7'b0110011,
    7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [16:0] ov(input logic [4:0] we_adr, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic [2:0] imm);
    return {we_adr, rs, a, b, alu, imm};
  endfunction

  // care flags: {adr_src, result_src, alu_src_a, alu_src_b, alu_control, imm_src}
  function automatic logic [16:0] mk(input logic [5:0] c);
    return {4'b1111, c[5], {2{c[4]}}, {2{c[3]}}, {2{c[2]}}, {3{c[1]}}, {3{c[0]}}};
  endfunction

  function automatic logic [2:0] exp_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;
      3'd7:    return 3'b010;
      3'd6:    return 3'b011;
      3'd4:    return 3'b100;
      3'd2:    return 3'b101;
      3'd3:    return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic zr, input logic sg,
                      input logic [16:0] o, input logic [16:0] m);
    cyc_t c;
    c = '{st: st, op: b_op, f3: b_f3, f7: b_f7, mr: mr, zr: zr, sg: sg, ov: o, mk: m};
    exp_q.push_back(c);
  endtask

  task automatic push_aluwb();
    push(4'd8, rb(), rb(), rb(), ov(5'b00100, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0), mk(6'b010000));
  endtask

  // Reference model: expected cycle trace for one instruction.
  // fs/ms: cycles mem_ready stays low in FETCH / in the data access.
  // fz: forced zero flag for branches (-1 = random).
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input int fs, input int ms, input int fz);
    logic z, s, tk;
    b_op = op; b_f3 = f3; b_f7 = f7;
    for (int i = 0; i < fs; i++)
      push(4'd0, 1'b0, rb(), rb(), ov(5'b00000, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0), mk(6'b111110));
    push(4'd0, 1'b1, rb(), rb(), ov(5'b11000, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0), mk(6'b111110));
    push(4'd1, rb(), rb(), rb(), ov(5'b00000, 2'b00, 2'b01, 2'b01, 3'd0,
         (op == 7'b1101111) ? 3'b100 : 3'b010), mk(6'b001111));
    case (op)
      7'b0000011: begin
        push(4'd2, rb(), rb(), rb(), ov(5'b00000, 2'b00, 2'b10, 2'b01, 3'd0, 3'b000), mk(6'b001111));
        for (int i = 0; i < ms; i++)
          push(4'd3, 1'b0, rb(), rb(), ov(5'b00001, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0), mk(6'b110000));
        push(4'd3, 1'b1, rb(), rb(), ov(5'b00001, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0), mk(6'b110000));
        push(4'd4, rb(), rb(), rb(), ov(5'b00100, 2'b01, 2'b00, 2'b00, 3'd0, 3'd0), mk(6'b010000));
      end
      7'b0100011: begin
        push(4'd2, rb(), rb(), rb(), ov(5'b00000, 2'b00, 2'b10, 2'b01, 3'd0, 3'b001), mk(6'b001111));
        for (int i = 0; i < ms; i++)
          push(4'd5, 1'b0, rb(), rb(), ov(5'b00011, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0), mk(6'b110000));
        push(4'd5, 1'b1, rb(), rb(), ov(5'b00011, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0), mk(6'b110000));
      end
      7'b0110011: begin
        push(4'd6, rb(), rb(), rb(), ov(5'b00000, 2'b00, 2'b10, 2'b00, exp_alu(1'b1, f3, f7), 3'd0),
             mk(6'b001110));
        push_aluwb();
      end
      7'b0010011: begin
        push(4'd7, rb(), rb(), rb(), ov(5'b00000, 2'b00, 2'b10, 2'b01, exp_alu(1'b0, f3, f7), 3'b000),
             mk(6'b001111));
        push_aluwb();
      end
      7'b1100011: begin
        z = (fz < 0) ? rb() : fz[0];
        s = rb();
        case (f3)
          3'd0:    tk = z;
          3'd1:    tk = !z;
          3'd4:    tk = s;
          3'd5:    tk = !s;
          default: tk = 1'b0;
        endcase
        push(4'd9, rb(), z, s, ov({tk, 4'b0000}, 2'b00, 2'b10, 2'b00, 3'b001, 3'd0), mk(6'b011110));
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111)
          push(4'd11, rb(), rb(), rb(), ov(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000), mk(6'b001111));
        push(4'd10, rb(), rb(), rb(), ov(5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 3'd0), mk(6'b011110));
        push_aluwb();
      end
      7'b0110111:
        push(4'd12, rb(), rb(), rb(), ov(5'b00100, 2'b11, 2'b00, 2'b00, 3'd0, 3'b011), mk(6'b010001));
      default:
        push(4'd13, rb(), rb(), rb(), ov(5'b00000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0), mk(6'b000000));
    endcase
  endtask

  // Driver + scoreboard: entered and left at a falling edge
  task automatic drain(input int n);
    cyc_t c;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      c = exp_q.pop_front();
      bus.op = c.op; bus.funct3 = c.f3; bus.funct7_5 = c.f7;
      bus.mem_ready = c.mr; bus.zero = c.zr; bus.sign = c.sg;
      #1;
      check("state", 32'(bus.state), 32'(c.st));
      check("outs", 32'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.adr_src,
                          bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
                          bus.imm_src} & c.mk), 32'(c.ov & c.mk));
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input int fs, input int ms, input int fz);
    build(op, f3, f7, fs, ms, fz);
    drain(exp_q.size());
  endtask

  function automatic logic [3:0] wes();
    return {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write};
  endfunction

  initial begin
    logic [6:0] rop;
    bus.op = 7'b0110011; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;
    bus.zero = 1'b0; bus.sign = 1'b0; bus.mem_ready = 1'b1;

    // Reset state: FETCH, no write enables even with mem_ready high
    #12;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_we", 32'(wes()), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    check("rst_illegal", 32'(bus.illegal), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run(7'b0110011, 3'd0, 1'b0, 0, 0, -1);   // add
    run(7'b0110011, 3'd0, 1'b1, 0, 0, -1);   // sub
    run(7'b0010011, 3'd0, 1'b1, 0, 0, -1);   // addi with IR[30]=1
    run(7'b0000011, 3'd2, 1'b0, 0, 2, -1);   // lw, 2 stall cycles
    run(7'b1100011, 3'd1, 1'b0, 0, 0, 1);    // bne, zero=1
    run(7'b1100011, 3'd1, 1'b0, 0, 0, 0);    // bne, zero=0
    run(7'b1100111, 3'd0, 1'b0, 0, 0, -1);   // jalr
    run(7'b1101111, 3'd0, 1'b0, 1, 0, -1);   // jal after a fetch stall
    run(7'b0100011, 3'd2, 1'b0, 0, 1, -1);   // sw, 1 stall cycle
    run(7'b0110111, 3'd0, 1'b0, 0, 0, -1);   // lui
    run(7'b0110011, 3'd1, 1'b0, 0, 0, -1);   // R-type unlisted funct3

    // Reset during MEMWRITE clears mem_write immediately
    build(7'b0100011, 3'd2, 1'b0, 0, 3, -1);
    drain(4);
    exp_q.delete();
    bus.mem_ready = 1'b0;
    #1;
    check("mw_before_rst", 32'({bus.state, bus.mem_write}), 32'({4'd5, 1'b1}));
    bus.mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("mw_rst_state", 32'(bus.state), 32'd0);
    check("mw_rst_we", 32'(wes()), 32'd0);
    @(negedge clk);
    check("mw_rst_hold_we", 32'(wes()), 32'd0);
    rst_n = 1'b1;

    // Reset during EXECUTER: no register write afterwards
    build(7'b0110011, 3'd7, 1'b0, 0, 0, -1);
    drain(2);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("ex_rst_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    check("ex_rst_we", 32'(wes()), 32'd0);
    rst_n = 1'b1;

    // Unsupported opcode
    run(7'b1111111, 3'd0, 1'b0, 0, 0, -1);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = rb();
      #1;
      check("trap_state", 32'(bus.state), 32'd13);
      check("trap_flag", 32'(bus.illegal), 32'd1);
      check("trap_we", 32'(wes()), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("trap_rst", 32'({bus.state, bus.illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    run(7'b0110111, 3'd0, 1'b0, 0, 0, -1);   // FETCH right after the NOP
`endif

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      rop = LEGAL_OPS[$urandom_range(0, 7)];
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) begin
        rop = 7'($urandom_range(0, 127));
        while (rop inside {LEGAL_OPS}) rop = 7'($urandom_range(0, 127));
      end
`endif
      run(rop, 3'($urandom_range(0, 7)), rb(),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle RV32I control unit that sequences a shared-ALU, single-memory datapath one instruction at a time through a Moore state machine. It drives every datapath mux select and write enable for PC, IR, register file and memory, and inserts wait cycles on a memory ready handshake. It supports add/sub/and/or/xor/slt/sltu (R and I), lw, sw, beq/bne/blt/bge, jal, jalr and lui.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode from the registered IR; valid from DECODE onward.
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- zero, sign  in  1  ALU result flags, from the current-cycle ALU result.
- mem_ready  in  1  memory completes the access in this cycle.
- pc_write, ir_write, reg_write, mem_write  out  1  write enables.
- adr_src  out  1  memory address select: 0 = PC, 1 = result bus.
- result_src  out  2  result bus select: 00 = ALUOut, 01 = Data, 10 = ALU result, 11 = ImmExt.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
- imm_src  out  3  immediate type: 000 I, 001 S, 010 B, 011 U, 100 J.
- illegal  out  1  unsupported opcode seen. Only present when ILLEGAL_TRAP_EN is defined.
- state  out  4  current state, for debug.

## Operation
All outputs are a function of state (Moore), plus op, funct3, funct7_5, zero, sign and mem_ready where stated below. Selects not listed for a state are don't-care. Write enables not listed for a state are 0.
- FETCH: adr_src=0, ir_write=pc_write=mem_ready, alu_src_a=00, alu_src_b=10, add, result_src=10. Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add. imm_src=100 if op=jal, else 010. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - any other opcode → ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src=000 for lw, 001 for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, result_src=00. Stay while !mem_ready; otherwise go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until mem_ready, then FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, then ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, imm_src=000, then ALUWB.
- ALU decode for EXECUTER and EXECUTEI, by funct3:
  - 000: sub only for R-type with funct7_5=1; add otherwise.
  - 111 and, 110 or, 100 xor, 010 slt, 011 sltu.
  - Any other funct3: add, with the register write still performed.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00. pc_write is the branch condition:
  - 000 zero, 001 !zero, 100 sign, 101 !sign.
  - Any other funct3: pc_write=0.
  - Then FETCH.
- JALR: alu_src_a=10, alu_src_b=01, imm_src=000, add, then JAL.
- JAL: result_src=00, pc_write=1, alu_src_a=01, alu_src_b=10, add (ALUOut takes OldPC+4), then ALUWB.
- LUI: imm_src=011, result_src=11, reg_write=1, then FETCH.
- ILLEGAL: see Configuration.

## Timing
- Cycle counts with mem_ready held high:
  - lui and taken or not-taken branch: 3 cycles.
  - R-type, I-type, sw and jal: 4 cycles.
  - lw and jalr: 5 cycles.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle. mem_ready in any other state is ignored.
- Reset:
  - rst_n low forces state to FETCH immediately (asynchronously).
  - While rst_n is low, pc_write, ir_write, reg_write and mem_write are 0.
  - First fetch is attempted on the first rising edge after rst_n deasserts.
- Reset asserted mid-instruction abandons that instruction; no partial register write occurs after the assertion.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, ILLEGAL=13. Codes 14 and 15 go to FETCH.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - ILLEGAL is terminal; all write enables are 0 in it.
  - illegal=1 while in ILLEGAL.
  - Only rst_n exits it.
- ILLEGAL_TRAP_EN undefined:
  - ILLEGAL lasts one cycle with no writes, then FETCH, so the instruction executes as a NOP.
  - The illegal port is absent.

## Structure
- Package mc_pkg holds:
  - the state enum;
  - opcode constants;
  - ALU, immediate, result_src, alu_src_a and alu_src_b code constants.
- Sub-module mc_alu_decoder: combinational; inputs state, op, funct3, funct7_5; output alu_control.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7_5 0), mem_ready=1 → states 0,1,6,8,0; alu_control=000 in EXECUTER; reg_write=1 only in ALUWB.
- sub (f7_5=1) → alu_control=001. addi with IR[30]=1 → alu_control=000.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; adr_src=1 throughout MEMREAD; reg_write and result_src=01 in MEMWB.
- bne with zero=1 → pc_write=0; with zero=0 → pc_write=1; both in cycle 3, then FETCH.
- jalr → states 0,1,11,10,8; pc_write in JAL with result_src=00; reg_write in ALUWB.
- Opcode 1111111 with the macro defined → illegal=1 and state stuck at 13 until rst_n. Macro undefined → FETCH on the next cycle. In both cases, rst_n pulsed low mid-MEMWRITE clears mem_write at once.
